// File: rtl/axil_write_engine.sv
// ============================================================================
// axil_write_engine : single-beat AXI4-Lite write master with B-channel timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module axil_write_engine #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_WDTH-1:0] wr_addr,
  input  logic [DATA_WDTH-1:0] wr_data,
  output logic                 done,
  output logic [RESP_WDTH-1:0] b_resp,
  output logic                 busy,
  output logic                 timeout,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_addr,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DATA_WDTH-1:0] w_data,
  input  logic                 b_valid,
  input  logic [RESP_WDTH-1:0] b_resp_in,
  output logic                 b_ready
);

  localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ADDR_DATA = 2'd1;
  localparam logic [1:0] S_WAIT_B    = 2'd2;
  localparam logic [1:0] S_DONE      = 2'd3;

  logic [1:0]           state_q,   state_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q,  w_done_d;
  logic [TMR_W-1:0]     timer_q,   timer_d;
  logic [ADDR_WDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WDTH-1:0] w_data_q,  w_data_d;
  logic [RESP_WDTH-1:0] b_resp_q,  b_resp_d;
  logic                 to_flag_q, to_flag_d;

  logic timer_expired;
  logic aw_hs;
  logic w_hs;

  assign timer_expired = (timer_q == TMR_MAX);
  assign aw_hs         = aw_valid & aw_ready;
  assign w_hs          = w_valid & w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      timer_q   <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      b_resp_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      timer_q   <= timer_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      b_resp_q  <= b_resp_d;
      to_flag_q <= to_flag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    timer_d   = timer_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    b_resp_d  = b_resp_q;
    to_flag_d = to_flag_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ADDR_DATA;
          aw_addr_d = wr_addr;
          w_data_d  = wr_data;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          timer_d   = '0;
          to_flag_d = 1'b0;
        end
      end
      S_ADDR_DATA: begin
        if (!timer_expired) timer_d = timer_q + 1'b1;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (timer_expired) begin
          state_d   = S_DONE;
          b_resp_d  = '0;
          to_flag_d = 1'b1;
        end else if (aw_done_d && w_done_d) begin
          state_d = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (!timer_expired) timer_d = timer_q + 1'b1;
        // A response arriving on the expiry cycle still counts as a normal completion
        if (b_valid) begin
          state_d   = S_DONE;
          b_resp_d  = b_resp_in;
          to_flag_d = 1'b0;
        end else if (timer_expired) begin
          state_d   = S_DONE;
          b_resp_d  = '0;
          to_flag_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        to_flag_d = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        timer_d   = '0;
        to_flag_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    b_ready  = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_ADDR_DATA: begin
        // Valids are withdrawn on the expiry cycle so no handshake races the abort
        aw_valid = !aw_done_q && !timer_expired;
        w_valid  = !w_done_q && !timer_expired;
        busy     = 1'b1;
      end
      S_WAIT_B: begin
        b_ready = 1'b1;
        busy    = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        timeout = to_flag_q;
        busy    = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign aw_addr = aw_addr_q;
  assign w_data  = w_data_q;
  assign b_resp  = b_resp_q;

endmodule

`default_nettype wire

// File: tb/tb_axil_write_engine.sv
// ============================================================================
// tb_axil_write_engine : directed self-checking bench for axil_write_engine
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axil_write_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        done;
  logic [0:0]  b_resp;
  logic        busy;
  logic        timeout;
  logic        aw_valid;
  logic        aw_ready;
  logic [3:0]  aw_addr;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic        b_valid;
  logic [0:0]  b_resp_in;
  logic        b_ready;

  int n_cmp = 0;
  int n_bad = 0;

  axil_write_engine #(
    .ADDR_WDTH(4),
    .DATA_WDTH(32),
    .RESP_WDTH(1),
    .TIMEOUT  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .done     (done),
    .b_resp   (b_resp),
    .busy     (busy),
    .timeout  (timeout),
    .aw_valid (aw_valid),
    .aw_ready (aw_ready),
    .aw_addr  (aw_addr),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .b_valid  (b_valid),
    .b_resp_in(b_resp_in),
    .b_ready  (b_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b1; wr_addr = 4'hF; wr_data = 32'hFFFF_FFFF;
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({aw_valid, w_valid, b_ready} !== 3'b000) begin n_bad++; $display("FAIL rst_valids: got %b want 000", {aw_valid, w_valid, b_ready}); end
    n_cmp++; if ({done, busy, timeout} !== 3'b000) begin n_bad++; $display("FAIL rst_status: got %b want 000", {done, busy, timeout}); end
    n_cmp++; if (b_resp !== 1'b0) begin n_bad++; $display("FAIL rst_b_resp: got %b want 0", b_resp); end
    n_cmp++; if ({aw_addr, w_data} !== 36'h0) begin n_bad++; $display("FAIL rst_addr_data: got %h want 0", {aw_addr, w_data}); end
    start = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp_in = 1'b1;
    wr_addr = 4'h3; wr_data = 32'hDEAD_BEEF; start = 1'b1;
    n_cmp++; if ({done, busy} !== 2'b00) begin n_bad++; $display("FAIL basic_start_cycle: got done,busy=%b want 00", {done, busy}); end
    tick();
    start = 1'b0; wr_addr = 4'h0; wr_data = 32'h0;
    n_cmp++; if ({aw_valid, w_valid, b_ready, busy, done} !== 5'b11010) begin n_bad++; $display("FAIL basic_c1_ctrl: got %b want 11010", {aw_valid, w_valid, b_ready, busy, done}); end
    n_cmp++; if (aw_addr !== 4'h3) begin n_bad++; $display("FAIL basic_aw_addr: got %h want 3", aw_addr); end
    n_cmp++; if (w_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL basic_w_data: got %h want deadbeef", w_data); end
    tick();
    n_cmp++; if ({aw_valid, w_valid, b_ready, done} !== 4'b0010) begin n_bad++; $display("FAIL basic_c2_ctrl: got %b want 0010", {aw_valid, w_valid, b_ready, done}); end
    tick();
    n_cmp++; if ({done, timeout, busy, b_resp} !== 4'b1011) begin n_bad++; $display("FAIL basic_done: got done,to,busy,resp=%b want 1011", {done, timeout, busy, b_resp}); end
    tick();
    n_cmp++; if ({done, busy, b_resp} !== 3'b001) begin n_bad++; $display("FAIL basic_after: got done,busy,resp=%b want 001", {done, busy, b_resp}); end
  endtask

  task automatic test_aw_delay;
    int aw_cnt = 0, w_cnt = 0, first_b = 0, done_cyc = 0, done_cnt = 0;
    aw_ready = 1'b0; w_ready = 1'b1; b_valid = 1'b1; b_resp_in = 1'b1;
    wr_addr = 4'h1; wr_data = 32'h0000_0001; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      aw_ready = (i >= 6);
      if (aw_valid) aw_cnt++;
      if (w_valid) w_cnt++;
      if (b_ready && first_b == 0) first_b = i;
      if (done) begin done_cnt++; done_cyc = i; end
      tick();
    end
    n_cmp++; if (aw_cnt !== 6) begin n_bad++; $display("FAIL awdly_aw_cycles: got %0d want 6", aw_cnt); end
    n_cmp++; if (w_cnt !== 1) begin n_bad++; $display("FAIL awdly_w_cycles: got %0d want 1", w_cnt); end
    n_cmp++; if (first_b !== 7) begin n_bad++; $display("FAIL awdly_b_ready_cycle: got %0d want 7", first_b); end
    n_cmp++; if (done_cyc !== 8 || done_cnt !== 1) begin n_bad++; $display("FAIL awdly_done: got cycle %0d count %0d want 8/1", done_cyc, done_cnt); end
  endtask

  task automatic test_err_resp;
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp_in = 1'b0;
    wr_addr = 4'h2; wr_data = 32'h0000_0002; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_cmp++; if ({done, b_resp, timeout} !== 3'b100) begin n_bad++; $display("FAIL err_done: got done,resp,to=%b want 100", {done, b_resp, timeout}); end
    tick();
    b_resp_in = 1'b1;
    tick();
    tick();
    n_cmp++; if ({b_resp, busy} !== 2'b00) begin n_bad++; $display("FAIL err_hold: got resp,busy=%b want 00", {b_resp, busy}); end
  endtask

  task automatic test_back_to_back;
    aw_ready = 1'b0; w_ready = 1'b1; b_valid = 1'b1; b_resp_in = 1'b1;
    wr_addr = 4'h5; wr_data = 32'h1111_1111; start = 1'b1;
    tick();
    wr_addr = 4'hA; wr_data = 32'h2222_2222;
    n_cmp++; if ({aw_addr, busy} !== {4'h5, 1'b1}) begin n_bad++; $display("FAIL b2b_c1: got addr,busy=%h,%b want 5,1", aw_addr, busy); end
    tick();
    start = 1'b0; aw_ready = 1'b1;
    n_cmp++; if ({aw_addr, w_data, aw_valid} !== {4'h5, 32'h1111_1111, 1'b1}) begin n_bad++; $display("FAIL b2b_c2: got addr %h data %h awv %b want 5 11111111 1", aw_addr, w_data, aw_valid); end
    tick();
    tick();
    n_cmp++; if ({done, b_resp} !== 2'b11) begin n_bad++; $display("FAIL b2b_done: got done,resp=%b want 11", {done, b_resp}); end
    tick();
    tick();
    n_cmp++; if ({busy, aw_addr} !== {1'b0, 4'h5}) begin n_bad++; $display("FAIL b2b_ignored: got busy %b addr %h want 0 5", busy, aw_addr); end
  endtask

  task automatic test_timeout;
    int aw_cnt = 0, br_cnt = 0, done_cnt = 0, done_cyc = 0, to_stray = 0;
    logic to_at_done = 1'b0;
    logic resp_at_done = 1'b1;
    aw_ready = 1'b0; w_ready = 1'b1; b_valid = 1'b0; b_resp_in = 1'b1;
    wr_addr = 4'h6; wr_data = 32'h0000_0006; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (aw_valid) aw_cnt++;
      if (b_ready) br_cnt++;
      if (done) begin done_cnt++; done_cyc = i; to_at_done = timeout; resp_at_done = b_resp; end
      if (timeout && !done) to_stray++;
      tick();
    end
    n_cmp++; if (aw_cnt !== 8) begin n_bad++; $display("FAIL to_aw_cycles: got %0d want 8", aw_cnt); end
    n_cmp++; if (br_cnt !== 0) begin n_bad++; $display("FAIL to_b_ready: got %0d cycles want 0", br_cnt); end
    n_cmp++; if (done_cyc !== 10 || done_cnt !== 1) begin n_bad++; $display("FAIL to_done: got cycle %0d count %0d want 10/1", done_cyc, done_cnt); end
    n_cmp++; if ({to_at_done, resp_at_done} !== 2'b10 || to_stray !== 0) begin n_bad++; $display("FAIL to_flag: got to,resp=%b stray %0d want 10 0", {to_at_done, resp_at_done}, to_stray); end
  endtask

  task automatic test_b_race;
    int done_cnt = 0, done_cyc = 0;
    logic to_at_done = 1'b1;
    logic resp_at_done = 1'b0;
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0; b_resp_in = 1'b1;
    wr_addr = 4'h8; wr_data = 32'h0000_0008; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      b_valid = (i == 9);
      if (done) begin done_cnt++; done_cyc = i; to_at_done = timeout; resp_at_done = b_resp; end
      tick();
    end
    n_cmp++; if (done_cyc !== 10 || done_cnt !== 1) begin n_bad++; $display("FAIL race_done: got cycle %0d count %0d want 10/1", done_cyc, done_cnt); end
    n_cmp++; if ({to_at_done, resp_at_done} !== 2'b01) begin n_bad++; $display("FAIL race_resp: got to,resp=%b want 01", {to_at_done, resp_at_done}); end
  endtask

  task automatic test_reset_mid;
    int done_cnt = 0;
    aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b0; b_resp_in = 1'b1;
    wr_addr = 4'h9; wr_data = 32'hCAFE_F00D; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_wait_b: got b_ready %b want 1", b_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({aw_valid, w_valid, b_ready, done, busy, timeout, b_resp} !== 7'b0) begin n_bad++; $display("FAIL rmid_outputs: got %b want 0000000", {aw_valid, w_valid, b_ready, done, busy, timeout, b_resp}); end
    n_cmp++; if ({aw_addr, w_data} !== 36'h0) begin n_bad++; $display("FAIL rmid_addr_data: got %h want 0", {aw_addr, w_data}); end
    b_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (done) done_cnt++;
      tick();
    end
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_cnt); end
    wr_addr = 4'h7; wr_data = 32'h0000_0777; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if ({aw_valid, aw_addr} !== {1'b1, 4'h7}) begin n_bad++; $display("FAIL rmid_restart: got awv %b addr %h want 1 7", aw_valid, aw_addr); end
    tick();
    tick();
    n_cmp++; if ({done, b_resp, timeout} !== 3'b110) begin n_bad++; $display("FAIL rmid_restart_done: got done,resp,to=%b want 110", {done, b_resp, timeout}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_delay();
    test_err_resp();
    test_back_to_back();
    test_timeout();
    test_b_race();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axil_write_engine.md
AXIL_WRITE_ENGINE -- requirements
Module: axil_write_engine

Interface
REQ-001 The block SHALL have parameter ADDR_WDTH, default 4, meaning the write address width.
REQ-002 The block SHALL have parameter DATA_WDTH, default 32, meaning the write data width.
REQ-003 The block SHALL have parameter RESP_WDTH, default 1, meaning the response width; value 1 = OKAY, 0 = error.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles from start-accept to B handshake.
REQ-005 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: write request from the sort controller.
REQ-008 The block SHALL have port wr_addr, input, ADDR_WDTH bits: target address, sampled with start.
REQ-009 The block SHALL have port wr_data, input, DATA_WDTH bits: target data, sampled with start.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port b_resp, output, RESP_WDTH bits: result of the last completed write.
REQ-012 The block SHALL have port busy, output, 1 bit: a transaction is in flight.
REQ-013 The block SHALL have port timeout, output, 1 bit: one-cycle pulse, coincident with done, on abort.
REQ-014 The block SHALL have ports aw_valid (output, 1 bit), aw_ready (input, 1 bit) and aw_addr (output, ADDR_WDTH bits).
REQ-015 The block SHALL have ports w_valid (output, 1 bit), w_ready (input, 1 bit) and w_data (output, DATA_WDTH bits).
REQ-016 The block SHALL have ports b_valid (input, 1 bit), b_resp_in (input, RESP_WDTH bits) and b_ready (output, 1 bit).

Function
REQ-017 The FSM SHALL have states IDLE, ADDR_DATA, WAIT_B and DONE.
REQ-018 In IDLE with start=1, the block SHALL latch wr_addr/wr_data into aw_addr/w_data, clear the aw_done/w_done flags and timer, and go to ADDR_DATA.
REQ-019 Start SHALL be ignored in all states other than IDLE.
REQ-020 In ADDR_DATA, aw_valid SHALL equal !aw_done and w_valid SHALL equal !w_done; both channels operate concurrently and are driven from registers.
REQ-021 An AW handshake (aw_valid & aw_ready on a rising edge) SHALL set aw_done, and aw_valid SHALL be 0 from the next cycle.
REQ-022 The W channel SHALL behave identically to AW: a W handshake sets w_done, and w_valid is 0 from the next cycle.
REQ-023 The block SHALL go to WAIT_B once both flags are set, including when both handshakes occur in the same cycle.
REQ-024 aw_addr and w_data SHALL be stable while their valid is high.
REQ-025 Once asserted, a valid SHALL NOT drop before its handshake, except on timeout or reset.
REQ-026 In WAIT_B, b_ready SHALL be 1.
REQ-027 In WAIT_B with b_valid=1, the block SHALL register b_resp <= b_resp_in and go to DONE.
REQ-028 b_valid arriving before both AW and W complete SHALL be ignored, since b_ready=0 then.
REQ-029 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-030 Latency SHALL be: start-accept edge, then at least 1 cycle in ADDR_DATA, at least 1 in WAIT_B, then 1 in DONE.
REQ-031 With all readies and b_valid high, done SHALL rise 3 cycles after the start cycle.
REQ-032 done SHALL never be asserted in the same cycle that start is accepted.
REQ-033 busy SHALL be 1 in ADDR_DATA, WAIT_B and DONE, and 0 in IDLE.
REQ-034 b_resp SHALL hold its value until the next completion (normal or timeout), so the controller can read it after done.
REQ-035 A timer SHALL count cycles in ADDR_DATA and WAIT_B, saturating, with width clog2(TIMEOUT+1).
REQ-036 When the timer reaches TIMEOUT, the block SHALL drop all valids and b_ready, set b_resp to 0, and go to DONE.
REQ-037 In the DONE cycle entered by timeout, timeout SHALL be 1.
REQ-038 If a B handshake and timer expiry occur in the same cycle, the handshake SHALL win: b_resp <= b_resp_in and timeout = 0.
REQ-039 An undefined state encoding SHALL go to IDLE with all outputs deasserted.

Reset
REQ-040 When rst_n=0, the block SHALL immediately enter IDLE and clear the timer and flags.
REQ-041 During reset, aw_valid, w_valid, b_ready, done, busy and timeout SHALL all be 0.
REQ-042 During reset, b_resp SHALL be 0 and aw_addr/w_data SHALL be 0.
REQ-043 Reset mid-transaction SHALL abandon the transaction with no done pulse.

Verification
REQ-044 Addr=4'h3, data=32'hDEADBEEF, all readies high, b_resp_in=1 -> AW and W presented the cycle after start; done rises 3 cycles after start; b_resp=1; busy drops the cycle after done.
REQ-045 aw_ready delayed 5 cycles, w_ready immediate -> w_valid is high 1 cycle and aw_valid is high 6 cycles; b_ready rises only after the AW handshake.
REQ-046 b_resp_in=0 -> done pulses with b_resp=0 and timeout=0; b_resp remains 0 until the next completion.
REQ-047 TIMEOUT=8 with aw_ready held 0 -> aw_valid drops at the timer limit; done=1 and timeout=1 for one cycle; b_resp=0.
REQ-048 Start pulsed again while busy -> the second request is ignored, and aw_addr is unchanged.
REQ-049 rst_n asserted in WAIT_B -> all outputs are 0 immediately; no done pulse; the next start is processed normally.
